// File: rtl/monostable_scheduler.sv
// rtl/monostable_scheduler.sv - round-robin shared one-shot pulse generator with recovery time
module monostable_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_W     = 16,
  parameter int RETRIGGER = 0,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] trig,
  input  logic [CNT_W-1:0]   cfg_pulse_len,
  input  logic [CNT_W-1:0]   cfg_recover_len,
  output logic               pulse,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    active_id,
  output logic               busy,
  output logic [NUM_REQ-1:0] pending
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_RECOVER
  } state_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [ID_W-1:0]    LAST_ID  = ID_W'(NUM_REQ - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   len_m1_q;
  logic [CNT_W-1:0]   rec_q;
  logic [ID_W-1:0]    rr;
  logic [NUM_REQ-1:0] trig_q;

  logic [NUM_REQ-1:0] trig_edge;
  logic [NUM_REQ-1:0] active_oh;
  logic [NUM_REQ-1:0] queue_set;
  logic [NUM_REQ-1:0] win_oh;
  logic [NUM_REQ-1:0] grant_clr;
  logic               retrig_hit;
  logic               found;
  logic [ID_W-1:0]    win;
  logic [CNT_W-1:0]   pulse_len_m1;
  int                 sel;

  assign trig_edge    = trig & ~trig_q;
  assign active_oh    = ONE_HOT0 << active_id;
  assign win_oh       = ONE_HOT0 << win;
  assign pulse_len_m1 = (cfg_pulse_len == '0) ? '0 : cfg_pulse_len - CNT_W'(1);

  // With retrigger enabled, the owner's own edge during its pulse extends it instead of queueing.
  always_comb begin
    queue_set  = trig_edge;
    retrig_hit = 1'b0;
    if ((RETRIGGER != 0) && (state == S_PULSE)) begin
      queue_set  = trig_edge & ~active_oh;
      retrig_hit = |(trig_edge & active_oh);
    end
  end

  // Round-robin search: first pending source at or after the rr pointer, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sel   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel = (int'(rr) + k) % NUM_REQ;
      if (!found && pending[sel]) begin
        found = 1'b1;
        win   = ID_W'(sel);
      end
    end
  end

  assign grant_clr = ((state == S_IDLE) && found) ? win_oh : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      len_m1_q  <= '0;
      rec_q     <= '0;
      rr        <= '0;
      trig_q    <= '1;
      pulse     <= 1'b0;
      grant     <= '0;
      active_id <= '0;
      busy      <= 1'b0;
      pending   <= '0;
    end else begin
      trig_q  <= trig;
      grant   <= '0;
      pending <= (pending & ~grant_clr) | queue_set;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant     <= win_oh;
            pulse     <= 1'b1;
            busy      <= 1'b1;
            active_id <= win;
            len_m1_q  <= pulse_len_m1;
            rec_q     <= cfg_recover_len;
            cnt       <= pulse_len_m1;
            rr        <= (win == LAST_ID) ? '0 : win + ID_W'(1);
            state     <= S_PULSE;
          end
        end
        S_PULSE: begin
          if (retrig_hit) begin
            cnt <= len_m1_q;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            pulse <= 1'b0;
            if (rec_q != '0) begin
              cnt   <= rec_q - CNT_W'(1);
              state <= S_RECOVER;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        S_RECOVER: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
